stage_mo: RTL and testbench

- Memory Operation (MO) stage, directly downstream of the MA/MO pipeline latch.
- Consumes the latched instr/instr_set/pc plus the effective address and store data.
- Runs loads/stores against the data-memory req/ack port, stalling upstream until the access completes.
- Registers the instruction and its result into the MO/WB boundary.

---
 rtl/stage_mo_pkg.sv | 51 +++++
 rtl/stage_mo_latch4mowb.sv | 32 +++
 rtl/stage_mo.sv | 200 ++++++++++++++++++++
 tb/tb_stage_mo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_mo_pkg
// Description : Shared constants, state encodings and the MO/WB bundle type
//               for the Memory Operation stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_mo_pkg;

  // Base instruction set; memory opcodes only decode within it.
  localparam logic [3:0]  ISET_BASE     = 4'h0;

  // Opcode field lives in instr[11:8].
  localparam logic [3:0]  OP_LD         = 4'hA;
  localparam logic [3:0]  OP_ST         = 4'hB;

  // Stage FSM encodings.
  localparam logic [1:0]  S_IDLE        = 2'd0;
  localparam logic [1:0]  S_BUSY        = 2'd1;
  localparam logic [1:0]  S_DONE        = 2'd2;

  // Data returned for an access abandoned by the timeout.
  localparam logic [11:0] TIMEOUT_RDATA = 12'hFFF;

  // Contents of the MO/WB boundary register.
  typedef struct packed {
    logic [11:0] instr;
    logic [3:0]  iset;
    logic [11:0] pc;
    logic [11:0] result;
  } mowb_t;

  // True for a load or store of the base instruction set.
  function automatic logic is_mem_op(input logic [11:0] instr,
                                     input logic [3:0]  iset);
    return (iset == ISET_BASE) &&
           ((instr[11:8] == OP_LD) || (instr[11:8] == OP_ST));
  endfunction

  // Empty slot written into MO/WB while an access is in flight (also the reset value).
  function automatic mowb_t mowb_bubble();
    mowb_t b;
    b.instr  = 12'h000;
    b.iset   = ISET_BASE;
    b.pc     = 12'h000;
    b.result = 12'h000;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_mo_latch4mowb.sv
`default_nettype none
// ============================================================================
// Module      : stage_mo_latch4mowb
// Description : MO/WB boundary register. Loads on en, clears to a bubble on
//               synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mo_latch4mowb
  import stage_mo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  mowb_t d_i,
  output mowb_t q_o
);

  mowb_t r_q;

  // Boundary register: bubble on reset, load when downstream advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= mowb_bubble();
    end else if (en_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/stage_mo.sv
`default_nettype none
// ============================================================================
// Module      : stage_mo
// Description : Memory Operation stage. Runs loads/stores over a req/ack
//               data-memory port, stalls upstream while an access is open,
//               and registers instruction + result into MO/WB.
//               Optional macro MO_TIMEOUT_EN: abort an unacknowledged access
//               after TIMEOUT_CYCLES busy cycles, returning 12'hFFF and
//               pulsing fault_out on the commit edge.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mo
  import stage_mo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] instr_in,
  input  logic [3:0]  instr_set_in,
  input  logic [11:0] pc_in,
  input  logic [11:0] ea_in,
  input  logic [11:0] sdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic [11:0] instr_out,
  output logic [3:0]  instr_set_out,
  output logic [11:0] pc_out,
  output logic [11:0] result_out,
  output logic        fault_out
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range
    $error("stage_mo: TIMEOUT_CYCLES must be within 1..255");
  end

  logic [1:0]  state_q,   state_d;
  logic        req_q,     req_d;
  logic        we_q,      we_d;
  logic [11:0] addr_q,    addr_d;
  logic [11:0] wdata_q,   wdata_d;
  logic [11:0] buf_q,     buf_d;      // result held in DONE
  logic        buf_to_q,  buf_to_d;   // held result came from an abort
  logic        fault_q,   fault_d;

  logic        w_is_mem;
  logic        w_is_ld;
  logic        w_abort;
  logic        w_finish;
  logic [11:0] w_acc_val;
  logic        w_stall;
  mowb_t       w_lat_d;
  mowb_t       w_lat_q;

  assign w_is_mem = is_mem_op(instr_in, instr_set_in);
  assign w_is_ld  = (instr_in[11:8] == OP_LD);

`ifdef MO_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  // Abort fires on the busy cycle in which the count would reach the limit.
  assign w_abort = (state_q == S_BUSY) && !mem_ack && (cnt_q == c_TO_LAST);

  // Busy-cycle counter: held at zero outside BUSY so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else if (state_q != S_BUSY) begin
      cnt_q <= 8'd0;
    end else if (!mem_ack && !w_abort) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // An access completes on ack, or on abort when the timeout is built in.
  assign w_finish  = mem_ack || w_abort;
  assign w_acc_val = w_abort ? TIMEOUT_RDATA : (w_is_ld ? mem_rdata : 12'h000);

  // Next-state, stall and MO/WB data selection.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    buf_to_d = buf_to_q;
    fault_d  = 1'b0;
    w_stall  = 1'b0;
    w_lat_d  = mowb_bubble();

    case (state_q)
      S_IDLE: begin
        w_stall = w_is_mem;
        if (enable) begin
          if (w_is_mem) begin
            // Capture only; the request goes out from the register next cycle.
            req_d   = 1'b1;
            we_d    = (instr_in[11:8] == OP_ST);
            addr_d  = ea_in;
            wdata_d = sdata_in;
            state_d = S_BUSY;
          end else begin
            w_lat_d = '{instr: instr_in, iset: instr_set_in,
                        pc: pc_in, result: ea_in};
          end
        end
      end

      S_BUSY: begin
        if (w_finish) begin
          req_d = 1'b0;
          if (enable) begin
            // Release upstream on this very edge together with the commit.
            w_lat_d = '{instr: instr_in, iset: instr_set_in,
                        pc: pc_in, result: w_acc_val};
            fault_d = w_abort;
            state_d = S_IDLE;
          end else begin
            buf_d    = w_acc_val;
            buf_to_d = w_abort;
            w_stall  = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          w_stall = 1'b1;
        end
      end

      S_DONE: begin
        w_stall = !enable;
        if (enable) begin
          w_lat_d = '{instr: instr_in, iset: instr_set_in,
                      pc: pc_in, result: buf_q};
          fault_d = buf_to_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage state and memory-port registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 12'h000;
      wdata_q  <= 12'h000;
      buf_q    <= 12'h000;
      buf_to_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      buf_to_q <= buf_to_d;
      fault_q  <= fault_d;
    end
  end

  stage_mo_latch4mowb u_latch4mowb (
    .clk  (clk),
    .rst  (rst),
    .en_i (enable),
    .d_i  (w_lat_d),
    .q_o  (w_lat_q)
  );

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign stall_out     = w_stall;
  assign instr_out     = w_lat_q.instr;
  assign instr_set_out = w_lat_q.iset;
  assign pc_out        = w_lat_q.pc;
  assign result_out    = w_lat_q.result;
  assign fault_out     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_mo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_mo
// Description : Self-checking bench for stage_mo: directed scenarios with
//               literal expectations, then randomized traffic compared every
//               cycle against a transaction-level reference model.
//               Honours MO_TIMEOUT_EN (runs with TIMEOUT_CYCLES=4 then).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_mo;
  import stage_mo_pkg::*;

`ifdef MO_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, mem_ack;
  logic [11:0] instr_in, pc_in, ea_in, sdata_in, mem_rdata;
  logic [3:0]  instr_set_in;
  logic        mem_req, mem_we, stall_out, fault_out;
  logic [11:0] mem_addr, mem_wdata, instr_out, pc_out, result_out;
  logic [3:0]  instr_set_out;

  always #5 clk = ~clk;

  stage_mo #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .instr_in(instr_in), .instr_set_in(instr_set_in), .pc_in(pc_in),
    .ea_in(ea_in), .sdata_in(sdata_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_out(stall_out), .instr_out(instr_out),
    .instr_set_out(instr_set_out), .pc_out(pc_out),
    .result_out(result_out), .fault_out(fault_out)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string nm, input logic [11:0] act,
                     input logic [11:0] mdl, input logic [11:0] lit);
    chk({nm, "_dut"}, act, lit);
    chk({nm, "_model"}, mdl, lit);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_valid = 0;
  bit          m_waiting = 0;   // access issued, memory has not answered
  bit          m_held = 0;      // answered, result waiting for enable
  int          m_wait_cnt = 0;  // busy cycles already spent without answer
  logic [11:0] m_buf;
  bit          m_buf_fault;
  logic [11:0] e_instr, e_pc, e_res, e_addr, e_wdata;
  logic [3:0]  e_set;
  logic        e_req, e_we, e_fault;
  bit          last_stall = 0;

  function automatic bit in_is_mem();
    return (instr_set_in == ISET_BASE) &&
           (instr_in[11:8] == 4'hA || instr_in[11:8] == 4'hB);
  endfunction

  function automatic bit tout_now();
`ifdef MO_TIMEOUT_EN
    return m_waiting && !mem_ack && (m_wait_cnt + 1 == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_stall();
    if (m_held) return !enable;
    if (m_waiting) return !((mem_ack || tout_now()) && enable);
    return in_is_mem();
  endfunction

  task automatic put_out(input logic [11:0] i, input logic [3:0] s,
                         input logic [11:0] p, input logic [11:0] r);
    e_instr = i; e_set = s; e_pc = p; e_res = r;
  endtask

  task automatic model_step();
    bit          t;
    logic [11:0] v;
    e_fault = 1'b0;
    if (!rst) begin
      m_valid = 1; m_waiting = 0; m_held = 0; m_wait_cnt = 0;
      m_buf = 12'h0; m_buf_fault = 0;
      e_req = 0; e_we = 0; e_addr = 12'h0; e_wdata = 12'h0;
      put_out(12'h0, ISET_BASE, 12'h0, 12'h0);
    end else if (m_held) begin
      if (enable) begin
        put_out(instr_in, instr_set_in, pc_in, m_buf);
        e_fault = m_buf_fault;
        m_held = 0;
      end
    end else if (m_waiting) begin
      t = tout_now();
      if (mem_ack || t) begin
        v = t ? 12'hFFF : ((instr_in[11:8] == 4'hA) ? mem_rdata : 12'h000);
        e_req = 0;
        m_waiting = 0;
        if (enable) begin
          put_out(instr_in, instr_set_in, pc_in, v);
          e_fault = t;
        end else begin
          m_held = 1; m_buf = v; m_buf_fault = t;
        end
      end else begin
        m_wait_cnt++;
        if (enable) put_out(12'h0, ISET_BASE, 12'h0, 12'h0);
      end
    end else if (enable) begin
      if (in_is_mem()) begin
        e_req = 1; e_we = (instr_in[11:8] == 4'hB);
        e_addr = ea_in; e_wdata = sdata_in;
        m_waiting = 1; m_wait_cnt = 0;
        put_out(12'h0, ISET_BASE, 12'h0, 12'h0);
      end else begin
        put_out(instr_in, instr_set_in, pc_in, ea_in);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    last_stall = exp_stall();
    model_step();
    #2;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("stall_out",     {11'h0, stall_out}, {11'h0, exp_stall()});
      chk("mem_req",       {11'h0, mem_req},   {11'h0, e_req});
      chk("mem_we",        {11'h0, mem_we},    {11'h0, e_we});
      chk("mem_addr",      mem_addr,           e_addr);
      chk("mem_wdata",     mem_wdata,          e_wdata);
      chk("instr_out",     instr_out,          e_instr);
      chk("instr_set_out", {8'h0, instr_set_out}, {8'h0, e_set});
      chk("pc_out",        pc_out,             e_pc);
      chk("result_out",    result_out,         e_res);
      chk("fault_out",     {11'h0, fault_out}, {11'h0, e_fault});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; enable = 1'b1; mem_ack = 1'b0; mem_rdata = 12'h0;
    instr_in = 12'h0; instr_set_in = ISET_BASE; pc_in = 12'h0;
    ea_in = 12'h0; sdata_in = 12'h0;
    step();
    rst = 1'b1;

    // Non-memory instruction: one-cycle passthrough, no stall.
    instr_in = 12'h123; pc_in = 12'h010; ea_in = 12'h055;
    #1 chk("nm_stall", {11'h0, stall_out}, 12'h0);
    step();
    pin("nm_instr", instr_out, e_instr, 12'h123);
    pin("nm_pc", pc_out, e_pc, 12'h010);
    pin("nm_result", result_out, e_res, 12'h055);

    // Reset with dirty outputs.
    rst = 1'b0;
    step();
    pin("rst_instr", instr_out, e_instr, 12'h000);
    pin("rst_result", result_out, e_res, 12'h000);
    pin("rst_set", {8'h0, instr_set_out}, {8'h0, e_set}, {8'h0, ISET_BASE});
    pin("rst_req", {11'h0, mem_req}, {11'h0, e_req}, 12'h000);
    rst = 1'b1;

    // Load, acked on the second busy cycle.
    instr_in = 12'hA00; pc_in = 12'h020; ea_in = 12'h3C0;
    #1 chk("ld_cap_stall", {11'h0, stall_out}, 12'h1);
    chk("ld_cap_req", {11'h0, mem_req}, 12'h0);
    step();
    pin("ld_req1", {11'h0, mem_req}, {11'h0, e_req}, 12'h1);
    pin("ld_addr", mem_addr, e_addr, 12'h3C0);
    pin("ld_bubble", instr_out, e_instr, 12'h000);
    #1 chk("ld_busy_stall", {11'h0, stall_out}, 12'h1);
    step();
    pin("ld_req2", {11'h0, mem_req}, {11'h0, e_req}, 12'h1);
    mem_ack = 1'b1; mem_rdata = 12'h7E1;
    #1 chk("ld_ack_stall", {11'h0, stall_out}, 12'h0);
    step();
    mem_ack = 1'b0;
    pin("ld_req_drop", {11'h0, mem_req}, {11'h0, e_req}, 12'h0);
    pin("ld_result", result_out, e_res, 12'h7E1);
    pin("ld_instr", instr_out, e_instr, 12'hA00);

    // Store, acked while enable is low, committed two cycles later.
    instr_in = 12'hB00; pc_in = 12'h030; ea_in = 12'h040; sdata_in = 12'h5A5;
    step();
    pin("st_we", {11'h0, mem_we}, {11'h0, e_we}, 12'h1);
    pin("st_wdata", mem_wdata, e_wdata, 12'h5A5);
    enable = 1'b0; mem_ack = 1'b1; mem_rdata = 12'h123;
    #1 chk("st_ack_stall", {11'h0, stall_out}, 12'h1);
    step();
    mem_ack = 1'b0;
    pin("st_req_drop", {11'h0, mem_req}, {11'h0, e_req}, 12'h0);
    #1 chk("st_done_stall1", {11'h0, stall_out}, 12'h1);
    step();
    #1 chk("st_done_stall2", {11'h0, stall_out}, 12'h1);
    step();
    enable = 1'b1;
    #1 chk("st_commit_stall", {11'h0, stall_out}, 12'h0);
    step();
    pin("st_instr", instr_out, e_instr, 12'hB00);
    pin("st_result", result_out, e_res, 12'h000);

    // Reset in BUSY, then a spurious ack.
    instr_in = 12'hA00; ea_in = 12'h111;
    step();
    pin("rb_req", {11'h0, mem_req}, {11'h0, e_req}, 12'h1);
    rst = 1'b0;
    step();
    pin("rb_req_rst", {11'h0, mem_req}, {11'h0, e_req}, 12'h0);
    rst = 1'b1; instr_in = 12'h100; pc_in = 12'h040; ea_in = 12'h0AB;
    mem_ack = 1'b1; mem_rdata = 12'h7E1;
    #1 chk("rb_stall", {11'h0, stall_out}, 12'h0);
    step();
    mem_ack = 1'b0;
    pin("rb_result", result_out, e_res, 12'h0AB);
    pin("rb_instr", instr_out, e_instr, 12'h100);

`ifdef MO_TIMEOUT_EN
    // Load never acked: abort after TO busy cycles.
    instr_in = 12'hA00; pc_in = 12'h050; ea_in = 12'h222;
    step();
    for (int i = 0; i < TO - 1; i++) begin
      step();
      pin("to_req_hold", {11'h0, mem_req}, {11'h0, e_req}, 12'h1);
    end
    step();
    pin("to_req_drop", {11'h0, mem_req}, {11'h0, e_req}, 12'h0);
    pin("to_result", result_out, e_res, 12'hFFF);
    pin("to_fault", {11'h0, fault_out}, {11'h0, e_fault}, 12'h1);
    instr_in = 12'h100; ea_in = 12'h0AB; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    pin("to_fault_end", {11'h0, fault_out}, {11'h0, e_fault}, 12'h0);
    pin("to_late_ack", result_out, e_res, 12'h0AB);
`endif

    // Randomized traffic; upstream holds its instruction while stalled.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 79) != 0);
      enable    = ($urandom_range(0, 3) != 0);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = 12'($urandom);
      if (!last_stall) begin
        if ($urandom_range(0, 1) == 1) begin
          instr_set_in = ISET_BASE;
          instr_in = {(($urandom_range(0, 1) == 1) ? 4'hA : 4'hB), 8'($urandom)};
        end else begin
          instr_set_in = 4'($urandom);
          instr_in = 12'($urandom);
        end
        pc_in    = 12'($urandom);
        ea_in    = 12'($urandom);
        sdata_in = 12'($urandom);
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
